// File: rtl/dmem_ctrl.sv
// dmem_ctrl: data-memory access controller sitting after the M-stage register.
// Runs one req/ack bus transaction per load or store and freezes the pipeline
// with a combinational stall until the access is complete.
// Optional feature macro: DMEM_TIMEOUT_EN. When it is defined, a REQ cycle
// counter aborts a bus access that gets no ack within TIMEOUT cycles.
//
// Bus handshake: the controller raises mem_req with mem_we/mem_addr/mem_wdata/
// mem_be and holds all of them stable until it samples mem_ack=1 on a rising
// edge. mem_rdata is sampled only on that edge. mem_ack is ignored while
// mem_req=0, and a request abandoned by reset is simply dropped.
module dmem_ctrl #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                MemtoRegM,
    input  logic                MemWriteM,
    input  logic [DATA_W/8-1:0] byteEnableM,
    input  logic [ADDR_W-1:0]   ALUResultM,
    input  logic [DATA_W-1:0]   WriteDataM,
    output logic [DATA_W-1:0]   ReadDataM,
    output logic                stall,
    output logic                fault,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_be,
    input  logic                mem_ack,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic [1:0]          dbg_state
);

    localparam int BE_W = DATA_W / 8;

    // The counter is 8 bits wide, so TIMEOUT must fit in it.
    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_timeout_range
        $error("dmem_ctrl: TIMEOUT must be in 1..255");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;
    logic              access;
    logic              misaligned;
    logic              start;    // aligned access accepted in IDLE
    logic              bad;      // misaligned access rejected in IDLE
    logic              finish;   // ack received in REQ
    logic              abort;    // REQ gave up waiting (timeout build only)
    logic [DATA_W-1:0] rdata_masked;

    assign access    = MemtoRegM | MemWriteM;
    assign dbg_state = state;

    // Pipeline freeze: held while an access waits in IDLE or runs in REQ.
    assign stall = reset & (((state == IDLE) & access) | (state == REQ));

    // Alignment rule for the requested lane pattern.
    always_comb begin
        misaligned = 1'b0;
        case (byteEnableM)
            4'b1111:          misaligned = (ALUResultM[1:0] != 2'b00);
            4'b0011, 4'b1100: misaligned = ALUResultM[0];
            4'b0000:          misaligned = 1'b1;
            default:          misaligned = 1'b0;
        endcase
    end

    // Load data with disabled byte lanes forced to zero.
    always_comb begin
        rdata_masked = '0;
        for (int i = 0; i < BE_W; i++) begin
            if (mem_be[i]) begin
                rdata_masked[8*i +: 8] = mem_rdata[8*i +: 8];
            end
        end
    end

`ifdef DMEM_TIMEOUT_EN
    // Last count value before the counter would reach TIMEOUT.
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    logic [7:0] tmo_cnt;

    // Counts REQ cycles that passed without an ack.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tmo_cnt <= '0;
        end else if (start) begin
            tmo_cnt <= '0;
        end else if ((state == REQ) && !(mem_ack && mem_req)) begin
            tmo_cnt <= tmo_cnt + 8'd1;
        end
    end
`endif

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and the one-cycle events that steer the datapath.
    always_comb begin
        state_next = state;
        start      = 1'b0;
        bad        = 1'b0;
        finish     = 1'b0;
        abort      = 1'b0;
        case (state)
            IDLE: begin
                if (access) begin
                    if (misaligned) begin
                        bad        = 1'b1;
                        state_next = DONE;
                    end else begin
                        start      = 1'b1;
                        state_next = REQ;
                    end
                end
            end
            REQ: begin
                // An ack always wins over a timeout in the same cycle.
                if (mem_ack && mem_req) begin
                    finish     = 1'b1;
                    state_next = DONE;
                end
`ifdef DMEM_TIMEOUT_EN
                else if (tmo_cnt == TMO_LAST) begin
                    abort      = 1'b1;
                    state_next = DONE;
                end
`endif
            end
            DONE: begin
                // The pipeline advances here; the access is never restarted.
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Bus registers, load data and the fault pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ReadDataM <= '0;
            fault     <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= '0;
        end else begin
            fault <= bad | abort;
            if (start) begin
                mem_req   <= 1'b1;
                mem_we    <= MemWriteM;
                mem_addr  <= ALUResultM;
                mem_wdata <= WriteDataM;
                mem_be    <= byteEnableM;
            end
            if (bad) begin
                ReadDataM <= '0;
            end
            if (finish || abort) begin
                mem_req <= 1'b0;
            end
            if (finish && !mem_we) begin
                ReadDataM <= rdata_masked;
            end
            if (abort && !mem_we) begin
                ReadDataM <= DATA_W'(32'hDEADBEEF);
            end
        end
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: directed cases plus randomized accesses, with a
// transaction-level expectation model and a per-cycle compare process.
module tb_dmem_ctrl;

`ifdef DMEM_TIMEOUT_EN
    localparam int TMO_CYC = 4;
`else
    localparam int TMO_CYC = 0;
`endif

    // ---------------- clock / reset / DUT ----------------
    logic        clk = 1'b0;
    logic        reset;
    logic        MemtoRegM, MemWriteM;
    logic [3:0]  byteEnableM;
    logic [31:0] ALUResultM, WriteDataM;
    logic [31:0] ReadDataM;
    logic        stall, fault;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [1:0]  dbg_state;

    always #5 clk = ~clk;

    dmem_ctrl #(
        .ADDR_W (32),
        .DATA_W (32),
        .TIMEOUT(TMO_CYC == 0 ? 255 : TMO_CYC)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .MemtoRegM  (MemtoRegM),
        .MemWriteM  (MemWriteM),
        .byteEnableM(byteEnableM),
        .ALUResultM (ALUResultM),
        .WriteDataM (WriteDataM),
        .ReadDataM  (ReadDataM),
        .stall      (stall),
        .fault      (fault),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_be     (mem_be),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .dbg_state  (dbg_state)
    );

    // ---------------- scoreboard state ----------------
    int checks   = 0;
    int failures = 0;
    logic chk_en = 1'b0;

    // Expected outputs for the current cycle.
    logic        exp_stall = 1'b0;
    logic        exp_req   = 1'b0;
    logic        exp_fault = 1'b0;
    // Model of the architectural registers.
    logic [31:0] m_rd    = '0;
    logic        m_we    = 1'b0;
    logic [31:0] m_addr  = '0;
    logic [31:0] m_wdata = '0;
    logic [3:0]  m_be    = '0;

    logic [3:0] be_tab [8] = '{4'b1111, 4'b0011, 4'b1100, 4'b0001,
                               4'b0010, 4'b0100, 4'b1000, 4'b0000};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic is_misaligned(input logic [3:0] be, input logic [31:0] addr);
        if (be == 4'b0000) return 1'b1;
        if (be == 4'b1111) return (addr % 4) != 0;
        if (be == 4'b0011 || be == 4'b1100) return (addr % 2) != 0;
        return 1'b0;
    endfunction

    function automatic logic [31:0] lane_mask(input logic [3:0] be);
        return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

    // Compare process: outputs sampled on the falling edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("stall", {31'b0, stall}, {31'b0, exp_stall});
            check("mem_req", {31'b0, mem_req}, {31'b0, exp_req});
            check("fault", {31'b0, fault}, {31'b0, exp_fault});
            check("ReadDataM", ReadDataM, m_rd);
            if (exp_req) begin
                check("mem_we", {31'b0, mem_we}, {31'b0, m_we});
                check("mem_addr", mem_addr, m_addr);
                check("mem_wdata", mem_wdata, m_wdata);
                check("mem_be", {28'b0, mem_be}, {28'b0, m_be});
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        MemtoRegM   = 1'b0;
        MemWriteM   = 1'b0;
        byteEnableM = 4'($urandom_range(0, 15));
        ALUResultM  = $urandom;
        WriteDataM  = $urandom;
        mem_ack     = 1'($urandom_range(0, 1));
        mem_rdata   = $urandom;
        exp_stall   = 1'b0;
        exp_req     = 1'b0;
        exp_fault   = 1'b0;
    endtask

    task automatic idle_cycle();
        idle_inputs();
        step();
    endtask

    // One M-stage access from its IDLE cycle to the first cycle after DONE.
    // ack_k: REQ cycle (1-based) in which the bus acks.
    task automatic do_access(input logic ld, input logic st, input logic [3:0] be,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             input int ack_k, input logic [31:0] rdata);
        logic bad;
        logic aborted;
        logic is_ld;
        int   last;
        is_ld = ld & ~st;
        bad   = is_misaligned(be, addr);
        MemtoRegM   = ld;
        MemWriteM   = st;
        byteEnableM = be;
        ALUResultM  = addr;
        WriteDataM  = wdata;
        mem_ack     = 1'($urandom_range(0, 1));
        mem_rdata   = $urandom;
        exp_stall   = 1'b1;
        exp_req     = 1'b0;
        exp_fault   = 1'b0;
        step();
        if (bad) begin
            exp_stall = 1'b0;
            exp_fault = 1'b1;
            m_rd      = '0;
            mem_ack   = 1'($urandom_range(0, 1));
            step();
        end else begin
            m_we    = st;
            m_addr  = addr;
            m_wdata = wdata;
            m_be    = be;
            aborted = (TMO_CYC > 0) && (ack_k > TMO_CYC);
            last    = aborted ? TMO_CYC : ack_k;
            for (int c = 1; c <= last; c++) begin
                exp_req   = 1'b1;
                exp_stall = 1'b1;
                if (c == ack_k) begin
                    mem_ack   = 1'b1;
                    mem_rdata = rdata;
                end else begin
                    mem_ack   = 1'b0;
                    mem_rdata = $urandom;
                end
                step();
            end
            // DONE: M-stage inputs left asserted, they must be ignored.
            exp_req   = 1'b0;
            exp_stall = 1'b0;
            exp_fault = aborted;
            if (is_ld) m_rd = aborted ? 32'hDEADBEEF : (rdata & lane_mask(be));
            mem_ack   = 1'($urandom_range(0, 1));
            mem_rdata = $urandom;
            step();
        end
        idle_inputs();
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic        ld, st;
        logic [3:0]  be;
        logic [31:0] addr;
        int          kind;

        reset       = 1'b0;
        MemtoRegM   = 1'b1;
        MemWriteM   = 1'b0;
        byteEnableM = 4'b1111;
        ALUResultM  = 32'h100;
        WriteDataM  = 32'h0;
        mem_ack     = 1'b1;
        mem_rdata   = 32'hFFFFFFFF;
        #2;
        check("rst_ReadDataM", ReadDataM, 32'h0);
        check("rst_mem_req", {31'b0, mem_req}, 32'h0);
        check("rst_mem_we", {31'b0, mem_we}, 32'h0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        check("rst_mem_be", {28'b0, mem_be}, 32'h0);
        check("rst_fault", {31'b0, fault}, 32'h0);
        check("rst_stall", {31'b0, stall}, 32'h0);
        step();
        reset = 1'b1;
        idle_inputs();
        chk_en = 1'b1;
        step();

        // Word load, ack in the first REQ cycle.
        do_access(1'b1, 1'b0, 4'b1111, 32'h100, 32'h0, 1, 32'h12345678);
        check("plan_word_load", ReadDataM, 32'h12345678);
        // Byte store with a 5-cycle ack delay; load data must not change.
        do_access(1'b0, 1'b1, 4'b1000, 32'h203, 32'hAB000000, 5, 32'h55555555);
        check("plan_store_keeps_rd", ReadDataM, 32'h12345678);
        // Upper halfword load.
        do_access(1'b1, 1'b0, 4'b1100, 32'h102, 32'h0, 2, 32'hBEEFCAFE);
        check("plan_half_load", ReadDataM, 32'hBEEF0000);
        // Misaligned word load.
        do_access(1'b1, 1'b0, 4'b1111, 32'h101, 32'h0, 1, 32'h0);
        check("plan_misaligned_rd", ReadDataM, 32'h0);
        // Load after that, then an all-lanes-off store which must fault.
        do_access(1'b1, 1'b0, 4'b0001, 32'h007, 32'h0, 3, 32'hA1B2C3D4);
        check("byte_load_lane0", ReadDataM, 32'h000000D4);
        do_access(1'b0, 1'b1, 4'b0000, 32'h200, 32'h1, 1, 32'h0);
        check("be0_fault_rd", ReadDataM, 32'h0);
        // Load and store both set: must behave as a store.
        do_access(1'b1, 1'b1, 4'b1111, 32'h300, 32'hCAFEF00D, 2, 32'h99999999);

        // Reset asserted in the middle of a REQ phase.
        MemtoRegM   = 1'b1;
        MemWriteM   = 1'b0;
        byteEnableM = 4'b1111;
        ALUResultM  = 32'h400;
        mem_ack     = 1'b0;
        exp_stall   = 1'b1;
        exp_req     = 1'b0;
        step();
        m_we = 1'b0; m_addr = 32'h400; m_wdata = WriteDataM; m_be = 4'b1111;
        exp_req = 1'b1;
        #2;
        reset     = 1'b0;
        m_rd      = '0;
        exp_req   = 1'b0;
        exp_stall = 1'b0;
        exp_fault = 1'b0;
        #1;
        check("rst_mid_req", {31'b0, mem_req}, 32'h0);
        check("rst_mid_stall", {31'b0, stall}, 32'h0);
        step();
        reset = 1'b1;
        idle_inputs();
        step();
        do_access(1'b1, 1'b0, 4'b1111, 32'h404, 32'h0, 3, 32'h0BADF00D);
        check("after_reset_load", ReadDataM, 32'h0BADF00D);

        if (TMO_CYC > 0) begin
            do_access(1'b1, 1'b0, 4'b1111, 32'h500, 32'h0, 100, 32'h0);
            check("timeout_rd", ReadDataM, 32'hDEADBEEF);
        end

        // Randomized accesses with random idle gaps (including none).
        for (int n = 0; n < 200; n++) begin
            repeat ($urandom_range(0, 2)) idle_cycle();
            kind = $urandom_range(0, 2);
            ld   = (kind != 1);
            st   = (kind != 0);
            be   = be_tab[$urandom_range(0, 7)];
            addr = $urandom;
            do_access(ld, st, be, addr, $urandom, $urandom_range(1, 6), $urandom);
        end
        repeat (3) idle_cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
